// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared ATM types and constants for the vault arbiter and terminal FSMs
package atm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } atm_state_t;

  localparam int          AMT_W_DEF      = 16;
  localparam logic [15:0] VAULT_INIT_DEF = 16'd10000;

  // Terminal-side constants kept here so every terminal FSM agrees on them.
  localparam logic [15:0] PIN_CODE   = 16'd1234;
  localparam logic [15:0] AMOUNT_MAX = 16'd5000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, search starts just after last
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  // Offset N_REQ wraps back to last itself, so a lone requester can win again.
  always_comb begin
    win       = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!win_valid && req[(int'(last) + off) % N_REQ]) begin
        win_valid                          = 1'b1;
        win_idx                            = IDX_W'((int'(last) + off) % N_REQ);
        win[(int'(last) + off) % N_REQ]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_vault_arbiter.sv
// rtl/atm_vault_arbiter.sv - shares one cash vault between N_REQ terminals; ATM_TXN_COUNT_EN adds txn/reject counters
module atm_vault_arbiter
  import atm_pkg::*;
#(
  parameter int               N_REQ       = 4,
  parameter int               AMT_W       = AMT_W_DEF,
  parameter logic [AMT_W-1:0] VAULT_INIT  = AMT_W'(VAULT_INIT_DEF),
  parameter int               DISP_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AMT_W-1:0]   amount,
  input  logic                     refill,
  input  logic [AMT_W-1:0]         refill_amount,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     dispense,
  output logic                     done,
  output logic                     approved,
  output logic [AMT_W-1:0]         vault_balance
`ifdef ATM_TXN_COUNT_EN
  ,
  output logic [15:0]              txn_count,
  output logic [15:0]              reject_count
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DISP_CYCLES + 1);

  atm_state_t       state, state_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic [IDX_W-1:0] id_q, id_n;
  logic [IDX_W-1:0] last_q, last_n;
  logic [AMT_W-1:0] amt_q, amt_n;
  logic             appr_q, appr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [AMT_W-1:0] bal_q, bal_n;
  logic [AMT_W-1:0] debit;
  logic [AMT_W:0]   bal_sum;

  logic [N_REQ-1:0] win;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .last      (last_q),
    .win       (win),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      amt_q   <= '0;
      appr_q  <= 1'b0;
      cnt_q   <= '0;
      bal_q   <= VAULT_INIT;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      last_q  <= last_n;
      amt_q   <= amt_n;
      appr_q  <= appr_n;
      cnt_q   <= cnt_n;
      bal_q   <= bal_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    id_n    = id_q;
    last_n  = last_q;
    amt_n   = amt_q;
    appr_n  = appr_q;
    cnt_n   = cnt_q;
    debit   = '0;
    case (state)
      ST_IDLE: begin
        grant_n = '0;
        appr_n  = 1'b0;
        if (win_valid) begin
          grant_n = win;
          id_n    = win_idx;
          amt_n   = amount[int'(win_idx)*AMT_W +: AMT_W];
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Compares against the registered balance, so a same-cycle refill is not counted.
        if (amt_q == '0 || amt_q > bal_q) begin
          appr_n  = 1'b0;
          state_n = ST_DONE;
        end else begin
          cnt_n   = CNT_W'(DISP_CYCLES);
          state_n = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          debit   = amt_q;
          appr_n  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        last_n  = id_q;
        grant_n = '0;
        appr_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // One extra bit holds the carry; debit never exceeds the balance.
  always_comb begin
    bal_sum = {1'b0, bal_q} - {1'b0, debit}
            + (refill ? {1'b0, refill_amount} : {(AMT_W+1){1'b0}});
    bal_n   = bal_sum[AMT_W] ? {AMT_W{1'b1}} : bal_sum[AMT_W-1:0];
  end

  assign grant         = grant_q;
  assign grant_id      = id_q;
  assign busy          = (state != ST_IDLE);
  assign dispense      = (state == ST_DISPENSE);
  assign done          = (state == ST_DONE);
  assign approved      = appr_q;
  assign vault_balance = bal_q;

`ifdef ATM_TXN_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      txn_count    <= '0;
      reject_count <= '0;
    end else if (state == ST_DONE) begin
      if (appr_q) txn_count    <= txn_count + 16'd1;
      else        reject_count <= reject_count + 16'd1;
    end
  end
`endif

endmodule
